// File: rtl/qspi_flash_responder_if.sv
// QSPI flash pin bundle between a bus master and the flash responder.
// Master drives csb/clk/di; the responder returns do/oe per IO lane.
`timescale 1ns/1ps
interface qspi_flash_responder_if;
    logic       flash_csb;
    logic       flash_clk;
    logic [3:0] flash_di;
    logic [3:0] flash_do;
    logic [3:0] flash_oe;

    modport master (
        output flash_csb,
        output flash_clk,
        output flash_di,
        input  flash_do,
        input  flash_oe
    );

    modport slave (
        input  flash_csb,
        input  flash_clk,
        input  flash_di,
        output flash_do,
        output flash_oe
    );
endinterface

// File: rtl/qspi_flash_responder.sv
// SPI/QSPI flash emulator answering 0x03/0x0B/0xEB/0x9F reads from a byte memory.
// Ports: clk/rst, flash pin bundle (slave), mem_addr/mem_rdata, cmd_err pulse.
`timescale 1ns/1ps
module qspi_flash_responder #(
    parameter int          ADDR_W     = 16,
    parameter int          DUMMY_QUAD = 4,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
    input  logic                  clk,
    input  logic                  rst,
    qspi_flash_responder_if.slave flash,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  cmd_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_S,
        S_ADDR_Q,
        S_MODE,
        S_DUMMY,
        S_DATA_S,
        S_DATA_Q,
        S_ID,
        S_IGNORE
    } state_t;

    localparam logic [4:0] DQ_LAST = 5'(DUMMY_QUAD - 1);

    // Pin synchronizers are deliberately not reset: they keep tracking the
    // pins through rst, so releasing rst never fakes a csb or clk edge.
    logic       csb_s1_q, csb_s2_q, csb_prev_q;
    logic       sck_s1_q, sck_s2_q, sck_prev_q;
    logic [3:0] di_s1_q, di_s2_q;

    always_ff @(posedge clk) begin
        csb_s1_q   <= flash.flash_csb;
        csb_s2_q   <= csb_s1_q;
        csb_prev_q <= csb_s2_q;
        sck_s1_q   <= flash.flash_clk;
        sck_s2_q   <= sck_s1_q;
        sck_prev_q <= sck_s2_q;
        di_s1_q    <= flash.flash_di;
        di_s2_q    <= di_s1_q;
    end

    logic rise, fall, csb_fall;
    assign rise     = sck_s2_q & ~sck_prev_q;
    assign fall     = ~sck_s2_q & sck_prev_q;
    assign csb_fall = ~csb_s2_q & csb_prev_q;

    state_t state_q, state_d;

    logic [4:0]        cnt_q, cnt_d;
    logic [22:0]       in_q, in_d;
    logic              fast_q, fast_d;
    logic              quad_q, quad_d;
    logic              cont_q, cont_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        sh_q, sh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        do_q, do_d;
    logic [3:0]        oe_q, oe_d;
    logic              err_q, err_d;

    logic [7:0] op;
    logic [7:0] id_byte;
    logic [7:0] load_byte;
    logic [4:0] dummy_last;

    // Opcode completes with the bit arriving on this rise.
    assign op         = {in_q[6:0], di_s2_q[0]};
    assign dummy_last = quad_q ? DQ_LAST : 5'd7;

    always_comb begin
        case (idx_q)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    assign load_byte = (state_q == S_ID) ? id_byte : mem_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a high csb beats any clock edge in the same clk.
    always_comb begin
        state_d = state_q;
        if (csb_s2_q) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (csb_fall) begin
                        state_d = cont_q ? S_ADDR_Q : S_CMD;
                    end
                end
                S_CMD: begin
                    if (rise && cnt_q == 5'd7) begin
                        case (op)
                            8'h03, 8'h0B: state_d = S_ADDR_S;
                            8'hEB:        state_d = S_ADDR_Q;
                            8'h9F:        state_d = S_ID;
                            default:      state_d = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR_S: begin
                    if (rise && cnt_q == 5'd23) begin
                        state_d = fast_q ? S_DUMMY : S_DATA_S;
                    end
                end
                S_ADDR_Q: begin
                    if (rise && cnt_q == 5'd5) begin
                        state_d = S_MODE;
                    end
                end
                S_MODE: begin
                    if (rise && cnt_q == 5'd1) begin
                        state_d = S_DUMMY;
                    end
                end
                S_DUMMY: begin
                    if (rise && cnt_q == dummy_last) begin
                        state_d = quad_q ? S_DATA_Q : S_DATA_S;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output and datapath next-state logic.
    always_comb begin
        cnt_d  = cnt_q;
        in_d   = in_q;
        fast_d = fast_q;
        quad_d = quad_q;
        cont_d = cont_q;
        idx_d  = idx_q;
        sh_d   = sh_q;
        addr_d = addr_q;
        do_d   = do_q;
        oe_d   = 4'h0;
        err_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (csb_fall && cont_q) begin
                    quad_d = 1'b1;
                    fast_d = 1'b0;
                end
            end
            S_CMD: begin
                if (rise) begin
                    in_d  = {in_q[21:0], di_s2_q[0]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        fast_d = (op == 8'h0B);
                        quad_d = (op == 8'hEB);
                        idx_d  = 2'd0;
                        if (op == 8'hFF) begin
                            cont_d = 1'b0;
                        end
                        err_d = !(op inside {8'h03, 8'h0B, 8'hEB,
                                             8'h9F, 8'hFF});
                    end
                end
            end
            S_ADDR_S: begin
                if (rise) begin
                    in_d  = {in_q[21:0], di_s2_q[0]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        addr_d = ADDR_W'({in_q, di_s2_q[0]});
                    end
                end
            end
            S_ADDR_Q: begin
                if (rise) begin
                    in_d  = {in_q[18:0], di_s2_q};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd5) begin
                        addr_d = ADDR_W'({in_q[19:0], di_s2_q});
                    end
                end
            end
            S_MODE: begin
                if (rise) begin
                    in_d  = {in_q[18:0], di_s2_q};
                    cnt_d = cnt_q + 5'd1;
                    // M[5:4] sit in the low bits of the first nibble.
                    if (cnt_q == 5'd1) begin
                        cont_d = (in_q[1:0] == 2'b10);
                    end
                end
            end
            S_DUMMY: begin
                if (rise) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DATA_S, S_ID: begin
                oe_d = oe_q;
                if (fall) begin
                    cnt_d = cnt_q + 5'd1;
                    oe_d  = 4'b0010;
                    if (cnt_q[2:0] == 3'd0) begin
                        do_d = {2'b00, load_byte[7], 1'b0};
                        sh_d = {load_byte[6:0], 1'b0};
                        if (state_q == S_DATA_S) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end else if (idx_q != 2'd3) begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        do_d = {2'b00, sh_q[7], 1'b0};
                        sh_d = {sh_q[6:0], 1'b0};
                    end
                end
            end
            S_DATA_Q: begin
                oe_d = oe_q;
                if (fall) begin
                    cnt_d = cnt_q + 5'd1;
                    oe_d  = 4'hF;
                    if (!cnt_q[0]) begin
                        do_d   = mem_rdata[7:4];
                        sh_d   = {mem_rdata[3:0], 4'h0};
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        do_d = sh_q[7:4];
                    end
                end
            end
            default: begin
                oe_d = 4'h0;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = 5'd0;
        end
        if (csb_s2_q) begin
            oe_d = 4'h0;
            do_d = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 5'd0;
            in_q   <= 23'd0;
            fast_q <= 1'b0;
            quad_q <= 1'b0;
            cont_q <= 1'b0;
            idx_q  <= 2'd0;
            sh_q   <= 8'h00;
            addr_q <= '0;
            do_q   <= 4'h0;
            oe_q   <= 4'h0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            in_q   <= in_d;
            fast_q <= fast_d;
            quad_q <= quad_d;
            cont_q <= cont_d;
            idx_q  <= idx_d;
            sh_q   <= sh_d;
            addr_q <= addr_d;
            do_q   <= do_d;
            oe_q   <= oe_d;
            err_q  <= err_d;
        end
    end

    assign flash.flash_do = do_q;
    assign flash.flash_oe = oe_q;
    assign mem_addr       = addr_q;
    assign cmd_err        = err_q;

endmodule
